// File: rtl/mem_pkg.sv
// Shared types and default widths for the SDRAM port arbiter.
package mem_pkg;

  localparam int MEM_ADDR_W = 19;
  localparam int MEM_DATA_W = 32;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_ISSUE,
    ARB_WR_HOLD,
    ARB_RD_WAIT
  } arb_state_t;

endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// Round-robin selector: first requesting client at or above the pointer,
// wrapping modulo NUM_CLIENTS (which need not be a power of two).
module rr_pick
  import mem_pkg::*;
#(
  parameter int NUM_CLIENTS = 4,
  parameter int PW          = $clog2(NUM_CLIENTS)
) (
  input  logic [NUM_CLIENTS-1:0] req_i,
  input  logic [PW-1:0]          ptr_i,
  output logic [NUM_CLIENTS-1:0] onehot_o,
  output logic [PW-1:0]          idx_o,
  output logic                   valid_o
);

  // One spare bit so ptr+k never overflows before the explicit wrap.
  logic [PW:0]   sum;
  logic [PW-1:0] cand;
  logic          found;

  // Scan clients in priority order starting at the pointer; first hit wins.
  always_comb begin
    onehot_o = '0;
    idx_o    = '0;
    found    = 1'b0;
    sum      = '0;
    cand     = '0;
    for (int k = 0; k < NUM_CLIENTS; k++) begin
      sum = {1'b0, ptr_i} + (PW+1)'(k);
      if (sum >= (PW+1)'(NUM_CLIENTS)) begin
        sum = sum - (PW+1)'(NUM_CLIENTS);
      end
      cand = sum[PW-1:0];
      if (!found && req_i[cand]) begin
        found          = 1'b1;
        onehot_o[cand] = 1'b1;
        idx_o          = cand;
      end
    end
    valid_o = found;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one SDRAM controller write/read port pair
// among NUM_CLIENTS requesters, one operation in flight at a time.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int NUM_CLIENTS = 4,
  parameter int ADDR_W      = MEM_ADDR_W,
  parameter int DATA_W      = MEM_DATA_W,
  parameter int WR_HOLD     = 4,
  parameter int RD_TIMEOUT  = 64
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_CLIENTS-1:0]        cl_req,
  input  logic [NUM_CLIENTS-1:0]        cl_we,
  input  logic [NUM_CLIENTS*ADDR_W-1:0] cl_addr,
  input  logic [NUM_CLIENTS*DATA_W-1:0] cl_wdata,
  output logic [NUM_CLIENTS-1:0]        cl_grant,
  output logic [NUM_CLIENTS-1:0]        cl_rvalid,
  output logic                          cl_rerr,
  output logic [DATA_W-1:0]             cl_rdata,
  output logic                          busy,
  output logic                          mem_wr_req,
  output logic [ADDR_W-1:0]             mem_wr_ad,
  output logic [DATA_W-1:0]             mem_wr_data,
  input  logic                          mem_wr_granted,
  output logic                          mem_rd_req,
  output logic [ADDR_W-1:0]             mem_rd_ad,
  input  logic                          mem_rd_granted,
  input  logic                          mem_rd_valid,
  input  logic [DATA_W-1:0]             mem_rd_data
);

  localparam int PW = $clog2(NUM_CLIENTS);

  arb_state_t               state_q, state_d;
  logic [PW-1:0]            ptr_q, ptr_d;
  logic [PW-1:0]            owner_q, owner_d;
  logic                     we_q, we_d;
  logic [ADDR_W-1:0]        addr_q, addr_d;
  logic [DATA_W-1:0]        wdata_q, wdata_d;
  logic [7:0]               cnt_q, cnt_d;
  logic [NUM_CLIENTS-1:0]   grant_q, grant_d;
  logic [NUM_CLIENTS-1:0]   rvalid_q, rvalid_d;
  logic                     rerr_q, rerr_d;
  logic [DATA_W-1:0]        rdata_q, rdata_d;
  logic                     wr_req_q, wr_req_d;
  logic                     rd_req_q, rd_req_d;
  logic                     busy_q, busy_d;

  logic [NUM_CLIENTS-1:0]   pick_onehot;
  logic [PW-1:0]            pick_idx;
  logic                     pick_valid;
  logic                     sel_we;
  logic [ADDR_W-1:0]        sel_addr;
  logic [DATA_W-1:0]        sel_wdata;

  rr_pick #(
    .NUM_CLIENTS (NUM_CLIENTS)
  ) u_pick (
    .req_i    (cl_req),
    .ptr_i    (ptr_q),
    .onehot_o (pick_onehot),
    .idx_o    (pick_idx),
    .valid_o  (pick_valid)
  );

  // Mux the winning client's operation fields using the one-hot winner.
  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      if (pick_onehot[i]) begin
        sel_we    = cl_we[i];
        sel_addr  = cl_addr[i*ADDR_W +: ADDR_W];
        sel_wdata = cl_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  // Next-state and registered-output logic; pulses default low every cycle.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    owner_d  = owner_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    cnt_d    = cnt_q;
    grant_d  = '0;
    rvalid_d = '0;
    rerr_d   = 1'b0;
    rdata_d  = rdata_q;
    wr_req_d = wr_req_q;
    rd_req_d = rd_req_q;

    unique case (state_q)
      ARB_IDLE: begin
        if (pick_valid) begin
          owner_d  = pick_idx;
          we_d     = sel_we;
          addr_d   = sel_addr;
          wdata_d  = sel_wdata;
          grant_d  = pick_onehot;
          wr_req_d = sel_we;
          rd_req_d = !sel_we;
          ptr_d    = (pick_idx == PW'(NUM_CLIENTS-1)) ? '0 : pick_idx + PW'(1);
          state_d  = ARB_ISSUE;
        end
      end
      // No timeout here: the controller may legitimately stall for refresh.
      ARB_ISSUE: begin
        if (we_q && mem_wr_granted) begin
          wr_req_d = 1'b0;
          cnt_d    = '0;
          state_d  = ARB_WR_HOLD;
        end else if (!we_q && mem_rd_granted) begin
          rd_req_d = 1'b0;
          cnt_d    = '0;
          state_d  = ARB_RD_WAIT;
        end
      end
      // Address/data registers are only loaded in IDLE, so they stay frozen here.
      ARB_WR_HOLD: begin
        if (cnt_q == 8'(WR_HOLD-1)) begin
          state_d = ARB_IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ARB_RD_WAIT: begin
        if (mem_rd_valid) begin
          rvalid_d[owner_q] = 1'b1;
          rdata_d           = mem_rd_data;
          state_d           = ARB_IDLE;
        end else if (cnt_q == 8'(RD_TIMEOUT-1)) begin
          rvalid_d[owner_q] = 1'b1;
          rerr_d            = 1'b1;
          rdata_d           = '0;
          state_d           = ARB_IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = ARB_IDLE;
    endcase

    busy_d = (state_d != ARB_IDLE);
  end

  // State and output registers; reset clears everything so outputs read 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ARB_IDLE;
      ptr_q    <= '0;
      owner_q  <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      cnt_q    <= '0;
      grant_q  <= '0;
      rvalid_q <= '0;
      rerr_q   <= 1'b0;
      rdata_q  <= '0;
      wr_req_q <= 1'b0;
      rd_req_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      owner_q  <= owner_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      cnt_q    <= cnt_d;
      grant_q  <= grant_d;
      rvalid_q <= rvalid_d;
      rerr_q   <= rerr_d;
      rdata_q  <= rdata_d;
      wr_req_q <= wr_req_d;
      rd_req_q <= rd_req_d;
      busy_q   <= busy_d;
    end
  end

  assign cl_grant    = grant_q;
  assign cl_rvalid   = rvalid_q;
  assign cl_rerr     = rerr_q;
  assign cl_rdata    = rdata_q;
  assign busy        = busy_q;
  assign mem_wr_req  = wr_req_q;
  assign mem_wr_ad   = addr_q;
  assign mem_wr_data = wdata_q;
  assign mem_rd_req  = rd_req_q;
  assign mem_rd_ad   = addr_q;

endmodule
